pixel_wr_packer: RTL and testbench
==================================

PIXEL_WR_PACKER -- requirements
Module: pixel_wr_packer

Interface
REQ-001 SHALL have parameter H_PIXELS, default 1280, pixels per line (multiple of 8).
REQ-002 SHALL have parameter V_LINES, default 720, lines per frame.
REQ-003 SHALL have parameter FRAME_BASE0, default 32'h0000_0000, byte address of frame buffer 0.
REQ-004 SHALL have parameter FRAME_BASE1, default 32'h0020_0000, byte address of frame buffer 1.
REQ-005 SHALL have ports: I_Clk in 1, the only clock; Rst in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: I_Pix_Vsync in 1, frame sync, level; I_Pix_Valid in 1, pixel strobe; I_Pix_Data in 16, RGB565 pixel.
REQ-007 SHALL have ports: I_Wdata_Fifo_Full in 1, write FIFO full; O_Wdata_Fifo_Wr_Data out 128, packed word; O_Wdata_Fifo_Wr_Vaild out 1, write strobe.
REQ-008 SHALL have ports: O_Aw_Wr_Trigger out 1, frame-start pulse to DMA; O_Waddr out 32, current frame base; O_Hcnt out 16, O_Vcnt out 16, pixel/line counters; O_Overflow out 1, sticky drop flag.

Function
REQ-009 SHALL implement states IDLE, WAIT_FRAME, PACK, FLUSH.
REQ-010 SHALL move IDLE->WAIT_FRAME one cycle after reset release.
REQ-011 SHALL, in WAIT_FRAME, on a rising edge of I_Pix_Vsync, go to PACK, clear O_Hcnt/O_Vcnt, and assert O_Aw_Wr_Trigger for exactly one cycle.
REQ-012 SHALL, in PACK, shift each valid pixel into the packing register with the first pixel of a word in bits [15:0] and the eighth pixel in [127:112].
REQ-013 SHALL assert O_Wdata_Fifo_Wr_Vaild for one cycle, with the packed word, one cycle after the eighth pixel is accepted.
REQ-014 SHALL increment O_Hcnt per valid pixel.
REQ-015 SHALL, when O_Hcnt reaches H_PIXELS, reset O_Hcnt to 0 and increment O_Vcnt.
REQ-016 SHALL, on a falling edge of I_Pix_Valid while 1-7 pixels are pending, enter FLUSH.
REQ-017 SHALL, in FLUSH, zero-pad the unfilled slots, write the word in one cycle, and return to PACK.
REQ-018 SHALL go to WAIT_FRAME and toggle the buffer select when O_Vcnt reaches V_LINES after its final word is written.
REQ-019 SHALL, if a rising edge of I_Pix_Vsync occurs in PACK, discard the pending partial word, toggle the buffer select, pulse O_Aw_Wr_Trigger, and restart counters (resync).
REQ-020 SHALL, if a write is due while I_Wdata_Fifo_Full=1, suppress the strobe, drop the word, and set O_Overflow until reset.
REQ-021 SHALL drive O_Waddr with FRAME_BASE0 when buffer select is 0 and FRAME_BASE1 when it is 1, updated in the same cycle as O_Aw_Wr_Trigger.
REQ-022 SHALL ignore I_Pix_Valid outside PACK.
REQ-023 SHALL perform all counter arithmetic at 16 bits with no wrap before the H_PIXELS/V_LINES limit.

Reset
REQ-024 SHALL, on Rst low, immediately force state IDLE and all outputs to 0, O_Waddr to FRAME_BASE0, and buffer select to 0.
REQ-025 SHALL, on reset mid-frame, discard the partial word, and SHALL write nothing until the next Vsync rising edge.

Configuration
REQ-026 SHALL, with macro PACKER_PINGPONG_EN defined, alternate buffers per REQ-018/019.
REQ-027 SHALL, without PACKER_PINGPONG_EN, hold buffer select at 0 so O_Waddr=FRAME_BASE0 always.

Structure
REQ-028 SHALL place the state enum and default frame-base/size constants in shared package dma_pkg.
REQ-029 SHALL use one sub-module, edge_detect, for the Vsync and Valid rising/falling edges.

Verification
REQ-030 SHALL cover: reset, Vsync rise, 8 pixels 16'h0001..16'h0008 -> one trigger pulse; one write of 128'h0008_0007_0006_0005_0004_0003_0002_0001; O_Waddr=FRAME_BASE0.
REQ-031 SHALL cover: 3 pixels AAAA,BBBB,CCCC then Valid falls -> FLUSH writes 128'h0..0_CCCC_BBBB_AAAA.
REQ-032 SHALL cover: H_PIXELS=16, V_LINES=2, full frame -> 4 writes; O_Vcnt=2; WAIT_FRAME; second frame O_Waddr=FRAME_BASE1 (PACKER_PINGPONG_EN defined).
REQ-033 SHALL cover: Full=1 at 8th pixel -> no strobe; O_Overflow=1 persists until Rst low.
REQ-034 SHALL cover: Vsync rise after 5 pixels in PACK -> no write of partial; trigger pulse; O_Hcnt=0.
REQ-035 SHALL cover: Rst low mid-word -> outputs 0 the same cycle; pixels ignored until next Vsync rise.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and default geometry for the pixel-to-DMA write path.
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_PACK       = 2'd2,
    ST_FLUSH      = 2'd3
  } state_e;

  localparam int unsigned DEF_H_PIXELS    = 1280;
  localparam int unsigned DEF_V_LINES     = 720;
  localparam logic [31:0] DEF_FRAME_BASE0 = 32'h0000_0000;
  localparam logic [31:0] DEF_FRAME_BASE1 = 32'h0020_0000;

  localparam int unsigned PIX_W  = 16;
  localparam int unsigned WORD_W = 128;

endpackage

// File: rtl/edge_detect.sv
// Single-bit edge detector: registers the input and flags a rising or falling
// transition (selected by RISING) combinationally in the cycle it is seen.
module edge_detect #(
  parameter bit RISING = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic edge_o
);

  logic prev_q, prev_d;

  always_comb begin
    prev_d = sig_i;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign edge_o = RISING ? (sig_i & ~prev_q) : (~sig_i & prev_q);

endmodule

// File: rtl/pixel_wr_packer.sv
// Packs RGB565 pixels into 128-bit FIFO words and sequences frame buffers for a DMA.
// Define PACKER_PINGPONG_EN to alternate between FRAME_BASE0 and FRAME_BASE1 per frame.
module pixel_wr_packer
  import dma_pkg::*;
#(
  parameter int unsigned H_PIXELS    = DEF_H_PIXELS,
  parameter int unsigned V_LINES     = DEF_V_LINES,
  parameter logic [31:0] FRAME_BASE0 = DEF_FRAME_BASE0,
  parameter logic [31:0] FRAME_BASE1 = DEF_FRAME_BASE1
) (
  input  logic                I_Clk,
  input  logic                Rst,
  input  logic                I_Pix_Vsync,
  input  logic                I_Pix_Valid,
  input  logic [PIX_W-1:0]    I_Pix_Data,
  input  logic                I_Wdata_Fifo_Full,
  output logic [WORD_W-1:0]   O_Wdata_Fifo_Wr_Data,
  output logic                O_Wdata_Fifo_Wr_Vaild,
  output logic                O_Aw_Wr_Trigger,
  output logic [31:0]         O_Waddr,
  output logic [15:0]         O_Hcnt,
  output logic [15:0]         O_Vcnt,
  output logic                O_Overflow
);

`ifdef PACKER_PINGPONG_EN
  localparam bit PINGPONG = 1'b1;
`else
  localparam bit PINGPONG = 1'b0;
`endif

  localparam logic [15:0] H_LAST = 16'(H_PIXELS - 1);
  localparam logic [15:0] V_LAST = 16'(V_LINES - 1);

  logic vsync_rise, valid_fall;

  edge_detect #(.RISING(1'b1)) u_vsync_edge (
    .clk    (I_Clk),
    .rst_n  (Rst),
    .sig_i  (I_Pix_Vsync),
    .edge_o (vsync_rise)
  );

  edge_detect #(.RISING(1'b0)) u_valid_edge (
    .clk    (I_Clk),
    .rst_n  (Rst),
    .sig_i  (I_Pix_Valid),
    .edge_o (valid_fall)
  );

  state_e              state_q, state_d;
  logic [2:0]          slot_q, slot_d;
  logic [WORD_W-1:0]   pack_q, pack_d;
  logic [15:0]         hcnt_q, hcnt_d;
  logic [15:0]         vcnt_q, vcnt_d;
  logic                buf_sel_q, buf_sel_d;
  logic                trig_q, trig_d;
  logic                wr_vld_q, wr_vld_d;
  logic [WORD_W-1:0]   wr_data_q, wr_data_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         waddr_q, waddr_d;

  logic                word_due, frame_start, buf_toggle, line_end, frame_end;
  logic [WORD_W-1:0]   word;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    pack_d      = pack_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    buf_sel_d   = buf_sel_q;
    trig_d      = 1'b0;
    wr_vld_d    = 1'b0;
    wr_data_d   = wr_data_q;
    ovf_d       = ovf_q;
    waddr_d     = waddr_q;
    word        = pack_q;
    word_due    = 1'b0;
    frame_start = 1'b0;
    buf_toggle  = 1'b0;
    line_end    = 1'b0;
    frame_end   = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_WAIT_FRAME;

      ST_WAIT_FRAME: begin
        if (vsync_rise) begin
          frame_start = 1'b1;
          state_d     = ST_PACK;
        end
      end

      ST_PACK: begin
        // A new frame mid-stream wins over any pixel or flush in the same cycle.
        if (vsync_rise) begin
          frame_start = 1'b1;
          buf_toggle  = 1'b1;
        end else if (I_Pix_Valid) begin
          word[{slot_q, 4'd0} +: PIX_W] = I_Pix_Data;
          pack_d    = word;
          slot_d    = slot_q + 3'd1;
          line_end  = (hcnt_q == H_LAST);
          frame_end = line_end && (vcnt_q == V_LAST);
          if (line_end) begin
            hcnt_d = 16'd0;
            vcnt_d = vcnt_q + 16'd1;
          end else begin
            hcnt_d = hcnt_q + 16'd1;
          end
          word_due = (slot_q == 3'd7) || frame_end;
          if (frame_end) begin
            state_d    = ST_WAIT_FRAME;
            buf_toggle = 1'b1;
          end
        end else if (valid_fall && (slot_q != 3'd0)) begin
          state_d = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        word_due = 1'b1;
        state_d  = ST_PACK;
      end

      default: state_d = ST_IDLE;
    endcase

    // Unfilled slots are already zero because the register clears after each word.
    if (word_due) begin
      pack_d = '0;
      slot_d = 3'd0;
      if (I_Wdata_Fifo_Full) begin
        ovf_d = 1'b1;
      end else begin
        wr_vld_d  = 1'b1;
        wr_data_d = word;
      end
    end

    if (frame_start) begin
      pack_d = '0;
      slot_d = 3'd0;
      hcnt_d = 16'd0;
      vcnt_d = 16'd0;
      trig_d = 1'b1;
    end

    if (buf_toggle) buf_sel_d = buf_sel_q ^ PINGPONG;
    if (frame_start) waddr_d = buf_sel_d ? FRAME_BASE1 : FRAME_BASE0;
  end

  always_ff @(posedge I_Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= ST_IDLE;
      slot_q    <= 3'd0;
      pack_q    <= '0;
      hcnt_q    <= 16'd0;
      vcnt_q    <= 16'd0;
      buf_sel_q <= 1'b0;
      trig_q    <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
      waddr_q   <= FRAME_BASE0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      pack_q    <= pack_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      buf_sel_q <= buf_sel_d;
      trig_q    <= trig_d;
      wr_vld_q  <= wr_vld_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
      waddr_q   <= waddr_d;
    end
  end

  assign O_Wdata_Fifo_Wr_Data  = wr_data_q;
  assign O_Wdata_Fifo_Wr_Vaild = wr_vld_q;
  assign O_Aw_Wr_Trigger       = trig_q;
  assign O_Waddr               = waddr_q;
  assign O_Hcnt                = hcnt_q;
  assign O_Vcnt                = vcnt_q;
  assign O_Overflow            = ovf_q;

endmodule

// File: tb/tb_pixel_wr_packer.sv
// Directed self-checking bench for pixel_wr_packer with a 16x2 frame geometry.
module tb_pixel_wr_packer;

  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] B1 = 32'h0020_0000;
`ifdef PACKER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vsync, valid, full;
  logic [15:0]  pix;
  logic [127:0] wr_data;
  logic         wr_vld, trig, ovf;
  logic [31:0]  waddr;
  logic [15:0]  hcnt, vcnt;

  always #5 clk = ~clk;

  pixel_wr_packer #(
    .H_PIXELS(16), .V_LINES(2), .FRAME_BASE0(B0), .FRAME_BASE1(B1)
  ) dut (
    .I_Clk                 (clk),
    .Rst                   (rst_n),
    .I_Pix_Vsync           (vsync),
    .I_Pix_Valid           (valid),
    .I_Pix_Data            (pix),
    .I_Wdata_Fifo_Full     (full),
    .O_Wdata_Fifo_Wr_Data  (wr_data),
    .O_Wdata_Fifo_Wr_Vaild (wr_vld),
    .O_Aw_Wr_Trigger       (trig),
    .O_Waddr               (waddr),
    .O_Hcnt                (hcnt),
    .O_Vcnt                (vcnt),
    .O_Overflow            (ovf)
  );

  int           checks = 0;
  int           errors = 0;
  int           wr_count = 0;
  int           trig_count = 0;
  logic [127:0] last_data = '0;
  bit           exp_sel = 1'b0;

  always @(negedge clk) begin
    if (wr_vld) begin
      wr_count++;
      last_data = wr_data;
    end
    if (trig) trig_count++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pix(input logic [15:0] d);
    valid = 1'b1;
    pix   = d;
    step();
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b0; valid = 1'b0; full = 1'b0; pix = '0;
    step(2);
    check("rst_trig", trig, 0);
    check("rst_vld", wr_vld, 0);
    check("rst_waddr", waddr, B0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    step(2);

    // Frame start and one full word of pixels 1..8.
    vsync = 1'b1;
    step();
    check("t1_trig", trig, 1);
    check("t1_waddr", waddr, B0);
    check("t1_hcnt0", hcnt, 0);
    vsync = 1'b0;
    for (int i = 1; i <= 8; i++) send_pix(16'(i));
    check("t1_vld", wr_vld, 1);
    check("t1_data", wr_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    valid = 1'b0;
    step();
    check("t1_vld_pulse", wr_vld, 0);
    step(2);
    check("t1_wr_count", wr_count, 1);
    check("t1_hcnt", hcnt, 8);

    // Resync after 5 pixels: partial word is dropped.
    for (int i = 0; i < 5; i++) send_pix(16'h0050 + 16'(i));
    check("rs_hcnt13", hcnt, 13);
    valid = 1'b0;
    vsync = 1'b1;
    step();
    exp_sel ^= PP;
    check("rs_trig", trig, 1);
    check("rs_hcnt", hcnt, 0);
    check("rs_waddr", waddr, exp_sel ? B1 : B0);
    vsync = 1'b0;
    step(3);
    check("rs_wr_count", wr_count, 1);

    // Three pixels then Valid falls: flush with zero padding.
    send_pix(16'hAAAA);
    send_pix(16'hBBBB);
    send_pix(16'hCCCC);
    valid = 1'b0;
    step(2);
    check("fl_vld", wr_vld, 1);
    check("fl_data", wr_data, 128'h0000_0000_0000_0000_0000_CCCC_BBBB_AAAA);
    step(2);
    check("fl_wr_count", wr_count, 2);
    check("fl_hcnt", hcnt, 3);

    // Full 16x2 frame via a resync, then the next frame from WAIT_FRAME.
    vsync = 1'b1;
    step();
    exp_sel ^= PP;
    check("fr_waddr0", waddr, exp_sel ? B1 : B0);
    vsync = 1'b0;
    for (int i = 0; i < 32; i++) begin
      send_pix(16'h0100 + 16'(i));
      if (i == 15) check("fr_line_wrap", hcnt, 0);
    end
    exp_sel ^= PP;
    valid = 1'b0;
    step(2);
    check("fr_wr_count", wr_count, 6);
    check("fr_last", last_data, 128'h011F_011E_011D_011C_011B_011A_0119_0118);
    check("fr_vcnt", vcnt, 2);
    check("fr_hcnt", hcnt, 0);
    send_pix(16'hDEAD);
    send_pix(16'hBEEF);
    valid = 1'b0;
    step(2);
    check("wf_ignore_hcnt", hcnt, 0);
    check("wf_ignore_vcnt", vcnt, 2);
    check("wf_wr_count", wr_count, 6);
    vsync = 1'b1;
    step();
    check("f2_trig", trig, 1);
    check("f2_waddr", waddr, exp_sel ? B1 : B0);
    check("f2_vcnt", vcnt, 0);
    vsync = 1'b0;

    // FIFO full on the eighth pixel: word dropped, overflow sticks.
    for (int i = 0; i < 7; i++) send_pix(16'h0200 + 16'(i));
    full = 1'b1;
    send_pix(16'h0207);
    check("ov_vld", wr_vld, 0);
    check("ov_flag", ovf, 1);
    valid = 1'b0;
    step();
    full = 1'b0;
    step(3);
    check("ov_wr_count", wr_count, 6);
    check("ov_sticky", ovf, 1);
    check("ov_hcnt", hcnt, 8);

    // Asynchronous reset mid-word.
    send_pix(16'h0300);
    send_pix(16'h0301);
    send_pix(16'h0302);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_ovf", ovf, 0);
    check("ar_hcnt", hcnt, 0);
    check("ar_data", wr_data, 0);
    check("ar_waddr", waddr, B0);
    exp_sel = 1'b0;
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send_pix(16'h0400 + 16'(i));
    valid = 1'b0;
    step(2);
    check("ar_ignore_wr", wr_count, 6);
    check("ar_ignore_hcnt", hcnt, 0);
    vsync = 1'b1;
    step();
    check("ar_trig", trig, 1);
    check("ar_waddr_new", waddr, B0);
    vsync = 1'b0;
    for (int i = 0; i < 8; i++) send_pix(16'h1000 + 16'(i));
    valid = 1'b0;
    step(2);
    check("ar_wr_count", wr_count, 7);
    check("ar_last", last_data, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
    check("trig_total", trig_count, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
